// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus: scanout read path, buffered write requester, clear control and SRAM port.
// Signal directions in the names are from the arbiter's point of view.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  i_active;
  logic [ADDR_WIDTH-1:0] i_rd_addr;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_rd_valid;

  logic                  i_wr_valid;
  logic [ADDR_WIDTH-1:0] i_wr_addr;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  o_wr_ready;

  logic                  i_clear_req;
  logic                  o_clear_busy;

  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_write;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  modport slave (
    input  i_active, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data, i_clear_req, i_mem_rdata,
    output o_rd_data, o_rd_valid, o_wr_ready, o_clear_busy, o_mem_addr, o_mem_write, o_mem_wdata
  );

  modport master (
    output i_active, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data, i_clear_req, i_mem_rdata,
    input  o_rd_data, o_rd_valid, o_wr_ready, o_clear_busy, o_mem_addr, o_mem_write, o_mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads always win; a write FIFO and a frame-clear
// engine share the blanking cycles round-robin.
module vram_arbiter #(
  parameter int unsigned           ADDR_WIDTH  = 19,
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           DEPTH       = 480000,
  parameter int unsigned           WFIFO_DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic           clk,
  input  logic           w_rst_n,
  vram_arbiter_if.slave  bus
);
  localparam int unsigned           PTR_W     = $clog2(WFIFO_DEPTH);
  localparam int unsigned           CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(WFIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  localparam logic [0:0] CLR_IDLE = 1'b0;
  localparam logic [0:0] CLR_BUSY = 1'b1;

  localparam logic GNT_WRITE = 1'b0;
  localparam logic GNT_CLEAR = 1'b1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_entry_t;

  // Clear engine
  logic [0:0]            clr_state, clr_state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr, clr_ptr_next;
  logic                  last_grant, last_grant_next;

  // Write FIFO
  wr_entry_t             fifo_mem [WFIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  wr_ready_q;
  logic                  fifo_empty;
  logic                  push, pop;
  wr_entry_t             head;

  // Port grant and memory-side drive
  logic                  scan_gnt, wr_gnt, clr_gnt;
  logic [ADDR_WIDTH-1:0] mem_addr_c, mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_c, mem_wdata_q;

  // Scanout return path
  logic                  active_d1;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];
  assign push       = bus.i_wr_valid && wr_ready_q;
  assign pop        = wr_gnt;

  // Per-cycle port owner; nothing is granted while reset is asserted
  always_comb begin
    scan_gnt = 1'b0;
    wr_gnt   = 1'b0;
    clr_gnt  = 1'b0;
    if (w_rst_n) begin
      if (bus.i_active) begin
        scan_gnt = 1'b1;
      end else if (!fifo_empty && (clr_state == CLR_BUSY)) begin
        if (last_grant == GNT_CLEAR) wr_gnt  = 1'b1;
        else                         clr_gnt = 1'b1;
      end else if (!fifo_empty) begin
        wr_gnt = 1'b1;
      end else if (clr_state == CLR_BUSY) begin
        clr_gnt = 1'b1;
      end
    end
  end

  // Memory address/data mux; an idle port holds the last driven values
  always_comb begin
    mem_addr_c  = mem_addr_q;
    mem_wdata_c = mem_wdata_q;
    if (scan_gnt) begin
      mem_addr_c = bus.i_rd_addr;
    end else if (wr_gnt) begin
      mem_addr_c  = head.addr;
      mem_wdata_c = head.data;
    end else if (clr_gnt) begin
      mem_addr_c  = clr_ptr;
      mem_wdata_c = CLEAR_VALUE;
    end
  end

  assign bus.o_mem_addr  = mem_addr_c;
  assign bus.o_mem_wdata = mem_wdata_c;
  assign bus.o_mem_write = wr_gnt || clr_gnt;

  // Clear engine next state: requests while busy are ignored, last address ends the frame
  always_comb begin
    clr_state_next  = clr_state;
    clr_ptr_next    = clr_ptr;
    last_grant_next = last_grant;
    if (wr_gnt)  last_grant_next = GNT_WRITE;
    if (clr_gnt) last_grant_next = GNT_CLEAR;
    case (clr_state)
      CLR_IDLE: begin
        if (bus.i_clear_req) clr_state_next = CLR_BUSY;
      end
      CLR_BUSY: begin
        if (clr_gnt) begin
          if (clr_ptr == LAST_ADDR) begin
            clr_state_next = CLR_IDLE;
            clr_ptr_next   = '0;
          end else begin
            clr_ptr_next = clr_ptr + ADDR_WIDTH'(1);
          end
        end
      end
      default: clr_state_next = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      clr_state  <= CLR_IDLE;
      clr_ptr    <= '0;
      last_grant <= GNT_CLEAR;
    end else begin
      clr_state  <= clr_state_next;
      clr_ptr    <= clr_ptr_next;
      last_grant <= last_grant_next;
    end
  end

  assign bus.o_clear_busy = (clr_state == CLR_BUSY);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // FIFO pointers and ready; ready tracks the post-edge occupancy
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      wr_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_next;
      wr_ready_q <= (count_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.i_wr_addr, bus.i_wr_data};
  end

  assign bus.o_wr_ready = wr_ready_q;

  // Held port values and the two-stage scanout return
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      active_d1   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      mem_addr_q  <= mem_addr_c;
      mem_wdata_q <= mem_wdata_c;
      active_d1   <= bus.i_active;
      rd_valid_q  <= active_d1;
      if (active_d1) rd_data_q <= bus.i_mem_rdata;
    end
  end

  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_rd_data  = rd_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: expected memory writes and scanout data are queued
// as stimulus is driven and retired as the DUT produces them.
module tb_vram_arbiter;
  localparam int unsigned AW    = 19;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned WFD   = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic w_rst_n;

  vram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vram_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .WFIFO_DEPTH (WFD),
    .CLEAR_VALUE (8'h00)
  ) dut (
    .clk     (clk),
    .w_rst_n (w_rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // SRAM stand-in: 1-cycle read returning the low address byte
  always @(posedge clk) bus.i_mem_rdata <= bus.o_mem_addr[DW-1:0];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_wr     = 0;
  int acc_cyc  = 0;
  int drop_cyc = 0;

  wr_t           exp_wq [$];
  logic [DW-1:0] rd_q   [$];
  logic          h1 = 1'b0;
  logic          h2 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: scanout latency/data, no writes during active video, write ordering
  always @(negedge clk) begin
    if (!w_rst_n) begin
      h1 <= 1'b0;
      h2 <= 1'b0;
    end else begin
      check("rd_valid", 32'(bus.o_rd_valid), 32'(h2));
      if (bus.o_rd_valid) begin
        if (rd_q.size() == 0) check("rd_unexp", 32'(bus.o_rd_valid), 32'd0);
        else begin
          check("rd_data", 32'(bus.o_rd_data), 32'(rd_q[0]));
          void'(rd_q.pop_front());
        end
      end
      if (bus.i_active) begin
        check("scan_nowr", 32'(bus.o_mem_write), 32'd0);
        check("scan_addr", 32'(bus.o_mem_addr), 32'(bus.i_rd_addr));
        rd_q.push_back(bus.i_rd_addr[DW-1:0]);
      end
      if (bus.o_mem_write) begin
        n_wr <= n_wr + 1;
        if (exp_wq.size() == 0) check("wr_unexp", 32'(bus.o_mem_write), 32'd0);
        else begin
          check("wr_addr", 32'(bus.o_mem_addr), 32'(exp_wq[0].addr));
          check("wr_data", 32'(bus.o_mem_wdata), 32'(exp_wq[0].data));
          void'(exp_wq.pop_front());
        end
      end
      h2 <= h1;
      h1 <= bus.i_active;
    end
  end

  task automatic idle_inputs();
    bus.i_active    = 1'b0;
    bus.i_rd_addr   = '0;
    bus.i_wr_valid  = 1'b0;
    bus.i_wr_addr   = '0;
    bus.i_wr_data   = '0;
    bus.i_clear_req = 1'b0;
  endtask

  task automatic do_reset();
    w_rst_n = 1'b0;
    idle_inputs();
    exp_wq.delete();
    rd_q.delete();
    repeat (2) @(posedge clk);
    #1 w_rst_n = 1'b1;
  endtask

  // Presents one write and returns one cycle after it is accepted; valid stays high
  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit sb);
    int budget;
    budget = 200;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = a;
    bus.i_wr_data  = d;
    while (!bus.o_wr_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("push_wait", 32'(bus.o_wr_ready), 32'd1);
    acc_cyc = cyc;
    if (sb) exp_wq.push_back({a, d});
    @(posedge clk); #1;
  endtask

  task automatic scan_cycles(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.i_active  = 1'b1;
      bus.i_rd_addr = AW'(base + i);
      @(posedge clk); #1;
    end
  endtask

  task automatic push_clear_exp(input int first, input int last);
    for (int i = first; i <= last; i++) exp_wq.push_back({AW'(i), 8'h00});
  endtask

  task automatic wait_addr(input string tag, input logic [AW-1:0] a);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (bus.o_mem_write && bus.o_mem_addr == a) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_busy_low(input string tag);
    int budget;
    budget = 300;
    while (bus.o_clear_busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, 32'(bus.o_clear_busy), 32'd0);
  endtask

  task automatic wait_drain(input string tag);
    int budget;
    budget = 300;
    while (exp_wq.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, 32'(exp_wq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int w0;
    w_rst_n = 1'b0;
    idle_inputs();
    #12;
    check("rst_rd_data",  32'(bus.o_rd_data),    32'd0);
    check("rst_rd_valid", 32'(bus.o_rd_valid),   32'd0);
    check("rst_wr_ready", 32'(bus.o_wr_ready),   32'd1);
    check("rst_busy",     32'(bus.o_clear_busy), 32'd0);
    check("rst_mem_wr",   32'(bus.o_mem_write),  32'd0);
    check("rst_mem_addr", 32'(bus.o_mem_addr),   32'd0);
    check("rst_mem_wd",   32'(bus.o_mem_wdata),  32'd0);
    @(posedge clk); #1 w_rst_n = 1'b1;

    // Scanout latency: addresses 0..7 return their low byte two cycles later
    scan_cycles(8, 0);
    bus.i_active = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("scan_drained", 32'(rd_q.size()), 32'd0);

    // Writes blocked by active video, then issued back-to-back in push order
    bus.i_active  = 1'b1;
    bus.i_rd_addr = AW'(5);
    push_wr(AW'(10), 8'hA1, 1'b1);
    push_wr(AW'(11), 8'hA2, 1'b1);
    push_wr(AW'(12), 8'hA3, 1'b1);
    bus.i_wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("blk_pending", 32'(exp_wq.size()), 32'd3);
    bus.i_active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("blk_burst", 32'(bus.o_mem_write), 32'd1);
    end
    @(negedge clk);
    check("blk_done", 32'(bus.o_mem_write), 32'd0);
    check("blk_drained", 32'(exp_wq.size()), 32'd0);

    // Backpressure: 16 fill the FIFO, the 17th waits for the first pop
    @(posedge clk); #1;
    bus.i_active = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_wr(AW'(1000 + i), DW'(i * 3 + 1), 1'b1);
      if (i == 14) check("bp_ready15", 32'(bus.o_wr_ready), 32'd1);
    end
    check("bp_full", 32'(bus.o_wr_ready), 32'd0);
    fork
      push_wr(AW'(1016), 8'h31, 1'b1);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          check("bp_hold", 32'(bus.o_wr_ready), 32'd0);
        end
        bus.i_active = 1'b0;
        drop_cyc = cyc;
      end
    join
    bus.i_wr_valid = 1'b0;
    check("bp_accept_lat", 32'(acc_cyc - drop_cyc), 32'd1);
    wait_drain("bp_drain");

    // Clear with contention: WRITE/CLEAR alternate, then the clear runs alone
    do_reset();
    bus.i_active = 1'b1;
    for (int i = 0; i < 4; i++) push_wr(AW'(100 + i), DW'(8'h50 + i), 1'b0);
    bus.i_wr_valid  = 1'b0;
    bus.i_clear_req = 1'b1;
    @(posedge clk); #1;
    bus.i_clear_req = 1'b0;
    check("clr_busy_set", 32'(bus.o_clear_busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      exp_wq.push_back({AW'(100 + i), DW'(8'h50 + i)});
      exp_wq.push_back({AW'(i), 8'h00});
    end
    push_clear_exp(4, DEPTH - 1);
    w0 = n_wr;
    bus.i_active = 1'b0;
    wait_addr("clr_last_seen", AW'(DEPTH - 1));
    check("clr_busy_last", 32'(bus.o_clear_busy), 32'd1);
    @(negedge clk);
    check("clr_busy_fall", 32'(bus.o_clear_busy), 32'd0);
    check("clr_total", 32'(n_wr - w0), 32'd68);
    check("clr_q_empty", 32'(exp_wq.size()), 32'd0);

    // Clear pause at clr_ptr=20, with a second request ignored mid-clear
    do_reset();
    bus.i_clear_req = 1'b1;
    @(posedge clk); #1;
    bus.i_clear_req = 1'b0;
    push_clear_exp(0, DEPTH - 1);
    wait_addr("pause_at19", AW'(19));
    @(posedge clk); #1;
    bus.i_clear_req = 1'b1;
    scan_cycles(1, 300);
    bus.i_clear_req = 1'b0;
    scan_cycles(9, 301);
    check("pause_left", 32'(exp_wq.size()), 32'd44);
    check("pause_busy", 32'(bus.o_clear_busy), 32'd1);
    bus.i_active = 1'b0;
    @(negedge clk);
    check("resume_addr", 32'(bus.o_mem_addr), 32'd20);
    wait_busy_low("pause_done");
    check("pause_q_empty", 32'(exp_wq.size()), 32'd0);

    // Async reset mid-clear with the FIFO still holding an entry
    do_reset();
    bus.i_active  = 1'b1;
    bus.i_rd_addr = AW'(7);
    for (int i = 0; i < 3; i++) push_wr(AW'(200 + i), DW'(8'hC0 + i), 1'b0);
    bus.i_wr_valid  = 1'b0;
    bus.i_clear_req = 1'b1;
    @(posedge clk); #1;
    bus.i_clear_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_wq.push_back({AW'(200 + i), DW'(8'hC0 + i)});
      exp_wq.push_back({AW'(i), 8'h00});
    end
    push_clear_exp(3, DEPTH - 1);
    bus.i_active = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_wr",   32'(bus.o_mem_write), 32'd1);
    check("pre_rst_data", 32'(bus.o_rd_data),   32'd7);
    w_rst_n = 1'b0;
    exp_wq.delete();
    rd_q.delete();
    #1;
    check("arst_mem_wr",   32'(bus.o_mem_write),  32'd0);
    check("arst_mem_addr", 32'(bus.o_mem_addr),   32'd0);
    check("arst_mem_wd",   32'(bus.o_mem_wdata),  32'd0);
    check("arst_busy",     32'(bus.o_clear_busy), 32'd0);
    check("arst_ready",    32'(bus.o_wr_ready),   32'd1);
    check("arst_rd_valid", 32'(bus.o_rd_valid),   32'd0);
    check("arst_rd_data",  32'(bus.o_rd_data),    32'd0);
    repeat (2) @(posedge clk);
    #1 w_rst_n = 1'b1;
    w0 = n_wr;
    repeat (100) @(posedge clk);
    #1;
    check("post_rst_busy",  32'(bus.o_clear_busy), 32'd0);
    check("post_rst_no_wr", 32'(n_wr - w0),        32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbiter and sequencer for the single-port VRAM frame buffer (`sram`, 1-cycle synchronous read). It shares the port between three users:
- the VGA scanout read path, which is guaranteed every cycle of active video;
- a buffered pixel-write requester, such as a sprite/entity renderer;
- a built-in frame-clear engine.

It sits between `vga_sync`/drawing logic and the `sram` instance, replacing direct address/write muxing in the top level.

## Interface
- `ADDR_WIDTH`, default 19: VRAM address width.
- `DATA_WIDTH`, default 8: palette-index bits per pixel.
- `DEPTH`, default 480000: pixel count (800×600); the clear engine covers addresses 0..DEPTH-1.
- `WFIFO_DEPTH`, default 16: write FIFO entries; must be a power of 2 and ≥ 2.
- `CLEAR_VALUE`, default 0: data written by the clear engine.

Ports:
- `clk`  in  1: pixel clock (40 MHz).
- `w_rst_n`  in  1: reset, asynchronous, active-low.
- `i_active`  in  1: display active region from `vga_sync`.
- `i_rd_addr`  in  ADDR_WIDTH: scanout read address; meaningful only while `i_active`=1.
- `o_rd_data`  out  DATA_WIDTH: scanout pixel data, registered.
- `o_rd_valid`  out  1: `o_rd_data` is valid.
- `i_wr_valid`  in  1: write request.
- `i_wr_addr`  in  ADDR_WIDTH: write address.
- `i_wr_data`  in  DATA_WIDTH: write data.
- `o_wr_ready`  out  1: FIFO not full.
- `i_clear_req`  in  1: single-cycle pulse that requests a full-frame clear.
- `o_clear_busy`  out  1: a clear is pending or in progress.
- `o_mem_addr`  out  ADDR_WIDTH: to `sram.i_addr`.
- `o_mem_write`  out  1: to `sram.i_write`.
- `o_mem_wdata`  out  DATA_WIDTH: to `sram.i_data`.
- `i_mem_rdata`  in  DATA_WIDTH: from `sram.o_data`.

## Operation
- **Port owner per cycle (combinational grant):**
  - `i_active`=1 → SCAN. `o_mem_addr`=`i_rd_addr`, `o_mem_write`=0. Scanout always wins.
  - `i_active`=0, with clear pending and FIFO non-empty → round-robin. Grant the requester not served last; a `last_grant` flag updates on every WRITE/CLEAR grant.
  - `i_active`=0, with only one requester → grant it. With neither → IDLE (`o_mem_write`=0, `o_mem_addr` holds its last value).
- **WRITE grant:** drive the FIFO head addr/data with `o_mem_write`=1, and pop the head on the same edge.
- **CLEAR grant:** drive `clr_ptr` and CLEAR_VALUE with `o_mem_write`=1.
  - `clr_ptr` increments on each grant.
  - The write at `clr_ptr`=DEPTH-1 completes the clear: `clr_ptr` returns to 0 and `o_clear_busy` falls on the next edge.
  - Active video pauses the clear; it resumes at the saved `clr_ptr`. A clear therefore spans multiple blanking intervals.
- **Clear request:**
  - `i_clear_req` while idle sets `o_clear_busy` on the next edge.
  - `i_clear_req` while busy is ignored; there is no restart.
- **Write FIFO:**
  - A push occurs when `i_wr_valid`&&`o_wr_ready`. `o_wr_ready`=!full.
  - Push and pop in the same cycle are legal, and the count is unchanged.
  - `i_wr_valid` while full is not accepted. The source must hold the request.
- **Ordering:** FIFO writes retire in push order. Between the FIFO and the clear engine, the later-granted write to an address wins.

## Timing
- **Read latency:** `i_rd_addr` at cycle t → `i_mem_rdata` at t+1 → `o_rd_data` at t+2. `o_rd_valid` equals `i_active` delayed 2 cycles.
- **Write latency:** a pushed entry that reaches the head at cycle t is granted at t if `i_active`=0, so the minimum is push at t, memory write at t+1.
- A full FIFO deasserts `o_wr_ready` in the cycle after the push that fills it. `o_wr_ready` reasserts the cycle after a pop.
- **Reset (async assert, sync release):**
  - Outputs: `o_rd_data`=0, `o_rd_valid`=0, `o_wr_ready`=1, `o_clear_busy`=0, `o_mem_write`=0, `o_mem_addr`=0, `o_mem_wdata`=0.
  - State: FIFO empty, `clr_ptr`=0, `last_grant`=CLEAR, so WRITE is granted first on a tie.
  - Reset mid-clear abandons the clear. Reset with a non-empty FIFO discards its entries.
- A write that is blocked by active video stalls only the FIFO. It never drops an entry.

## Test plan
- **Scanout latency:** `i_active`=1, `i_rd_addr`=0,1,2…, sram model returns addr[7:0] → `o_rd_data`=0,1,2… with `o_rd_valid`=1 starting 2 cycles after `i_active` rises, and `o_mem_write`=0 throughout.
- **Blocked writes:** push 3 writes (addr 10/11/12, data 0xA1/0xA2/0xA3) during `i_active`=1 → no memory write occurs. After `i_active` falls, `o_mem_write`=1 on 3 consecutive cycles with those addr/data, in order.
- **Backpressure:** push 17 writes back-to-back with `i_active`=1 and `WFIFO_DEPTH`=16 → `o_wr_ready`=0 after the 16th. The 17th is held, then accepted the cycle after the first pop.
- **Clear with contention:** `DEPTH`=64, FIFO holds 4 entries, pulse `i_clear_req`, `i_active`=0 → grants alternate WRITE, CLEAR, WRITE, CLEAR…. `o_clear_busy` falls after the CLEAR write to addr 63; total memory writes = 68.
- **Clear pause:** assert `i_active` during a clear at `clr_ptr`=20 → there are no clear writes while active, and the clear resumes at addr 20. A second `i_clear_req` mid-clear has no effect.
- **Async reset:** drop `w_rst_n` mid-clear with the FIFO non-empty → outputs take their reset values immediately, without a clock edge. After release, `o_clear_busy`=0 and no stale writes issue.
